// File: rtl/sha_core_arbiter_pkg.sv
// sha_core_arbiter_pkg: shared widths, core mode and FSM state type for the SHA core arbiter
package sha_core_arbiter_pkg;
    localparam int   SHA_BLOCK_W  = 512;
    localparam int   SHA_DIGEST_W = 256;
    localparam int   OWNER_W      = 2;
    localparam logic MODE_SHA_256 = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_ISSUE, ST_BUSY} state_t;
endpackage

// File: rtl/sha_core_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; search starts at last_owner+1 (mod CLIENTS)
//   req         in  per-client request
//   last_owner  in  index of the previous owner (lowest priority)
//   pick_onehot out one-hot winner, zero when no request
//   pick_idx    out index of the winner
module rr_pick
    import sha_core_arbiter_pkg::*;
#(
    parameter int CLIENTS = 2
) (
    input  logic [CLIENTS-1:0] req,
    input  logic [OWNER_W-1:0] last_owner,
    output logic [CLIENTS-1:0] pick_onehot,
    output logic [OWNER_W-1:0] pick_idx
);
    // Walk distances from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = last_owner;
        for (int d = CLIENTS; d >= 1; d--) begin
            for (int c = 0; c < CLIENTS; c++) begin
                if (req[c] && ((int'(last_owner) + d) % CLIENTS) == c) begin
                    pick_onehot    = '0;
                    pick_onehot[c] = 1'b1;
                    pick_idx       = OWNER_W'(c);
                end
            end
        end
    end
endmodule

// File: rtl/sha_core_arbiter.sv
// sha_core_arbiter: round-robin sharing of one sha256_core among CLIENTS requesters
//   req/gnt            level request per client, registered one-hot grant
//   cmd_init/cmd_next  owner command, sampled only in GRANT
//   block_in           client i block at [i*512 +: 512]
//   done/timeout_err   one-cycle completion strobe to owner, watchdog strobe
//   busy               state is not IDLE
//   core_*             sha256_core interface; digest passes core_digest through
module sha_core_arbiter
    import sha_core_arbiter_pkg::*;
#(
    parameter int CLIENTS        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CLIENTS-1:0]            req,
    output logic [CLIENTS-1:0]            gnt,
    input  logic [CLIENTS-1:0]            cmd_init,
    input  logic [CLIENTS-1:0]            cmd_next,
    input  logic [CLIENTS*SHA_BLOCK_W-1:0] block_in,
    output logic [CLIENTS-1:0]            done,
    output logic                          timeout_err,
    output logic                          busy,
    output logic [SHA_DIGEST_W-1:0]       digest,
    output logic                          core_init,
    output logic                          core_next,
    output logic                          core_mode,
    output logic [SHA_BLOCK_W-1:0]        core_block,
    input  logic                          core_ready,
    input  logic [SHA_DIGEST_W-1:0]       core_digest,
    input  logic                          core_digest_valid
);
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t                   r_state, w_state;
    logic [CLIENTS-1:0]       r_gnt, w_gnt, r_done, w_done, w_pick;
    logic [OWNER_W-1:0]       r_owner, w_owner, r_last, w_last, w_pick_idx;
    logic                     r_is_init, w_is_init, r_first, w_first, r_tmo, w_tmo;
    logic [SHA_BLOCK_W-1:0]   r_block, w_block, w_own_blk;
    logic [7:0]               r_wd, w_wd;
    logic                     w_own_req, w_own_init, w_own_next, w_unused;

    rr_pick #(.CLIENTS(CLIENTS)) u_pick (
        .req         (req),
        .last_owner  (r_last),
        .pick_onehot (w_pick),
        .pick_idx    (w_pick_idx)
    );

    // gnt is one-hot of the owner in GRANT, so masking with it selects the owner's inputs.
    assign w_own_req  = |(req & r_gnt);
    assign w_own_init = |(cmd_init & r_gnt);
    assign w_own_next = |(cmd_next & r_gnt);
    assign w_unused   = core_digest_valid;

    always_comb begin
        w_own_blk = '0;
        for (int c = 0; c < CLIENTS; c++)
            if (r_gnt[c]) w_own_blk = block_in[c*SHA_BLOCK_W +: SHA_BLOCK_W];
    end

    always_comb begin
        w_state   = r_state;
        w_gnt     = r_gnt;
        w_owner   = r_owner;
        w_last    = r_last;
        w_is_init = r_is_init;
        w_block   = r_block;
        w_wd      = r_wd;
        w_first   = r_first;
        w_done    = '0;
        w_tmo     = 1'b0;
        case (r_state)
            ST_IDLE: if (|req) begin
                w_state = ST_GRANT;
                w_gnt   = w_pick;
                w_owner = w_pick_idx;
            end
            ST_GRANT: if (!w_own_req) begin
                w_state = ST_IDLE;
                w_gnt   = '0;
                w_last  = r_owner;
            end else if (w_own_init || w_own_next) begin
                w_state   = ST_ISSUE;
                w_block   = w_own_blk;
                w_is_init = w_own_init;
            end
            ST_ISSUE: begin
                w_state = ST_BUSY;
                w_wd    = '0;
                w_first = 1'b1;
            end
            // The core still shows ready in the first BUSY cycle, so that cycle is skipped.
            ST_BUSY: if (r_first) begin
                w_first = 1'b0;
            end else if (core_ready) begin
                w_state = ST_GRANT;
                w_done  = r_gnt;
            end else if (r_wd >= WD_LIMIT) begin
                w_state = ST_GRANT;
                w_done  = r_gnt;
                w_tmo   = 1'b1;
            end else begin
                w_wd = (r_wd == 8'hFF) ? r_wd : r_wd + 8'd1;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_last    <= OWNER_W'(CLIENTS - 1);
            r_is_init <= 1'b0;
            r_block   <= '0;
            r_wd      <= '0;
            r_first   <= 1'b0;
            r_done    <= '0;
            r_tmo     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_gnt     <= w_gnt;
            r_owner   <= w_owner;
            r_last    <= w_last;
            r_is_init <= w_is_init;
            r_block   <= w_block;
            r_wd      <= w_wd;
            r_first   <= w_first;
            r_done    <= w_done;
            r_tmo     <= w_tmo;
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign timeout_err = r_tmo;
    assign busy        = r_state != ST_IDLE;
    assign core_init   = (r_state == ST_ISSUE) && r_is_init;
    assign core_next   = (r_state == ST_ISSUE) && !r_is_init;
    assign core_mode   = MODE_SHA_256;
    assign core_block  = r_block;
    assign digest      = core_digest;
endmodule
